apb_protocol_monitor: RTL
=========================

APB_PROTOCOL_MONITOR -- requirements
Module: apb_protocol_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: PADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: PWDATA width, a multiple of 8.
REQ-003 SHALL have parameter NUM_SLAVES, default 4: PSEL width.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum allowed wait cycles, at least 1.
REQ-005 SHALL have parameter CNT_WIDTH, default 8: width of all counters.
REQ-006 SHALL have port PCLK, input, 1 bit: the only clock; all sampling is on the rising edge.
REQ-007 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have inputs PADDR [ADDR_WIDTH], PWRITE [1], PWDATA [DATA_WIDTH], PSTRB [DATA_WIDTH/8], PSEL [NUM_SLAVES], PENABLE [1], PREADY [1] and PSLVERR [1]: the observed APB bus.
REQ-009 SHALL have input err_clr, 1 bit: synchronous clear of err_sticky and err_cnt.
REQ-010 SHALL have output err_pulse, 7 bits: registered single-cycle flags, indexed per REQ-014.
REQ-011 SHALL have output err_sticky, 7 bits: latched copy of err_pulse.
REQ-012 SHALL have outputs err_any [1] = |err_sticky and err_cnt [CNT_WIDTH] = error-cycle count.
REQ-013 SHALL have outputs wr_cnt, rd_cnt and slverr_cnt, each CNT_WIDTH: transfer statistics.

Function
REQ-014 SHALL use these error bits: 0 MULTI_SEL (more than one PSEL bit high); 1 SEQ (PENABLE high with no preceding SETUP, or SETUP not followed by PENABLE); 2 EN_NO_SEL (PENABLE high with PSEL all zero); 3 UNSTABLE (PADDR, PWRITE, PSEL, PSTRB, or PWDATA when PWRITE=1 differs from the SETUP capture while in ACCESS); 4 EN_STUCK (PENABLE still high the sample after completion); 5 TIMEOUT; 6 STRB_READ (PSTRB nonzero while PWRITE=0 and |PSEL).
REQ-015 SHALL have a tracking FSM with states IDLE, SETUP and WAIT.
REQ-016 IDLE: on |PSEL && !PENABLE, SHALL capture bus fields and go to SETUP; on PENABLE, SHALL flag SEQ (plus EN_NO_SEL if PSEL=0) and stay in IDLE.
REQ-017 SETUP: on PENABLE with PSEL matching the capture and PREADY=1, the transfer SHALL complete and the FSM SHALL go to IDLE.
REQ-018 SETUP: on PENABLE with PSEL matching the capture and PREADY=0, the FSM SHALL go to WAIT with wait_cnt=1.
REQ-019 SETUP: on !PENABLE, SHALL flag SEQ; the FSM SHALL re-enter SETUP with a fresh capture if |PSEL, else go to IDLE.
REQ-020 WAIT: stability SHALL be checked every sample; PREADY=1 SHALL complete and go to IDLE; otherwise wait_cnt SHALL increment.
REQ-021 WAIT: when wait_cnt reaches TIMEOUT with PREADY=0, SHALL flag TIMEOUT and go to IDLE, abandoning the transfer (no statistic counted).
REQ-022 WAIT: PENABLE or PSEL dropping before PREADY SHALL flag SEQ and go to IDLE.
REQ-023 Completion SHALL set a one-cycle done flag; PENABLE=1 at the next sample SHALL flag EN_STUCK in place of SEQ.
REQ-024 Back-to-back transfers (completion followed directly by a new SETUP) are legal and SHALL be error-free.
REQ-025 Every error detected at sample edge N SHALL appear on err_pulse for exactly the cycle after edge N (one-cycle latency).
REQ-026 Multiple errors in one sample SHALL set all their bits; err_cnt SHALL increment by exactly 1 per such cycle.
REQ-027 All counters SHALL saturate at all-ones and never wrap.
REQ-028 When err_clr and a new error occur in the same cycle, the new error's sticky bits SHALL be set and err_cnt SHALL be set to 1.

Reset
REQ-029 PRESET high SHALL immediately force: FSM=IDLE, done=0, wait_cnt=0, captures=0, err_pulse=0, err_sticky=0, err_any=0, err_cnt=0, wr_cnt=0, rd_cnt=0, slverr_cnt=0.
REQ-030 Reset mid-transfer SHALL abandon the transfer silently; the first sample after release SHALL be treated as IDLE.

Configuration
REQ-031 SHALL support macro APB_MON_STATS_EN; when defined, each completion SHALL increment wr_cnt (PWRITE=1) or rd_cnt (PWRITE=0), and slverr_cnt additionally if PSLVERR=1.
REQ-032 When APB_MON_STATS_EN is undefined, wr_cnt, rd_cnt and slverr_cnt SHALL be constant 0 with no counter logic.

Verification
REQ-033 Legal write to PADDR=0x10 with 2 wait states, then a back-to-back read with 0 waits: err_sticky=0, wr_cnt=1, rd_cnt=1 (STATS on).
REQ-034 PSEL=4'b0011 during SETUP: err_pulse[0] high for 1 cycle, err_cnt=1, err_any=1.
REQ-035 PADDR changes 0x10->0x14 in the second WAIT cycle: err_pulse[3] set once.
REQ-036 PREADY held low for 16 access cycles: err_pulse[5] set, FSM returns to IDLE, wr_cnt unchanged.
REQ-037 PENABLE held high 1 cycle after completion: err_pulse[4]=1 and err_pulse[1]=0; then err_clr together with a PSTRB=4'hF read: err_sticky=7'b1000000, err_cnt=1.
REQ-038 PRESET pulsed mid-WAIT, then a legal transfer: no errors flagged, all counters equal 0 before that transfer.

Source files
------------

// File: rtl/apb_protocol_monitor.sv
// -----------------------------------------------------------------------------
// apb_protocol_monitor
//
// Passive checker for an APB bus. A small IDLE/SETUP/WAIT tracker follows each
// transfer, captures the SETUP fields and compares them on every ACCESS sample.
// Seven error classes are reported as registered one-cycle pulses, a sticky
// copy, an any-error flag and a saturating count of error cycles.
//
// Optional feature: define APB_MON_STATS_EN to build the write/read/slave-error
// transfer statistics. Without it, wr_cnt/rd_cnt/slverr_cnt are tied to zero.
//
// Error bit map on err_pulse/err_sticky:
//   0 MULTI_SEL  1 SEQ  2 EN_NO_SEL  3 UNSTABLE  4 EN_STUCK  5 TIMEOUT
//   6 STRB_READ
// -----------------------------------------------------------------------------
module apb_protocol_monitor #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [NUM_SLAVES-1:0]   PSEL,
  input  logic                    PENABLE,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic                    err_clr,
  output logic [6:0]              err_pulse,
  output logic [6:0]              err_sticky,
  output logic                    err_any,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic [CNT_WIDTH-1:0]    wr_cnt,
  output logic [CNT_WIDTH-1:0]    rd_cnt,
  output logic [CNT_WIDTH-1:0]    slverr_cnt
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WAIT_WIDTH = $clog2(TIMEOUT + 1);

  // Error bit positions.
  localparam int ERR_MULTI_SEL = 0;
  localparam int ERR_SEQ       = 1;
  localparam int ERR_EN_NO_SEL = 2;
  localparam int ERR_UNSTABLE  = 3;
  localparam int ERR_EN_STUCK  = 4;
  localparam int ERR_TIMEOUT   = 5;
  localparam int ERR_STRB_READ = 6;

  // Last wait count that may still be extended; one more PREADY=0 sample
  // from here reaches TIMEOUT.
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WAIT_WIDTH-1:0]   wait_q, wait_d;
  logic                    done_q;

  // SETUP-phase capture used for the stability checks.
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic                    cap_write;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [STRB_WIDTH-1:0]   cap_strb;
  logic [NUM_SLAVES-1:0]   cap_sel;

  logic                    capture;
  logic                    complete;
  logic [6:0]              err_d;
  logic                    any_sel;
  logic                    multi_sel;
  logic                    fields_stable;

  assign any_sel   = |PSEL;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_sel = (PSEL & (PSEL - 1'b1)) != '0;

  assign fields_stable = (PADDR  == cap_addr)  &&
                         (PWRITE == cap_write) &&
                         (PSEL   == cap_sel)   &&
                         (PSTRB  == cap_strb)  &&
                         (!cap_write || (PWDATA == cap_wdata));

  // Next-state, capture/complete strobes and the error vector for this sample.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    wait_d   = '0;
    capture  = 1'b0;
    complete = 1'b0;
    err_d    = '0;

    // Bus-wide checks, independent of where the tracker is.
    err_d[ERR_MULTI_SEL] = multi_sel;
    err_d[ERR_EN_NO_SEL] = PENABLE && !any_sel;
    err_d[ERR_STRB_READ] = (|PSTRB) && !PWRITE && any_sel;

    case (state_q)
      ST_IDLE: begin
        if (PENABLE) begin
          // Enable lingering right after a completion is its own class.
          if (done_q) err_d[ERR_EN_STUCK] = 1'b1;
          else        err_d[ERR_SEQ]      = 1'b1;
        end else if (any_sel) begin
          capture = 1'b1;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (!PENABLE) begin
          err_d[ERR_SEQ] = 1'b1;
          if (any_sel) begin
            capture = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!any_sel) begin
          err_d[ERR_SEQ] = 1'b1;
          state_d        = ST_IDLE;
        end else if (PSEL != cap_sel) begin
          // Access addressed a different slave than the setup: give up.
          err_d[ERR_UNSTABLE] = 1'b1;
          state_d             = ST_IDLE;
        end else begin
          err_d[ERR_UNSTABLE] = !fields_stable;
          if (PREADY) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else if (TIMEOUT == 1) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d            = ST_IDLE;
          end else begin
            wait_d  = WAIT_WIDTH'(1);
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!PENABLE || !any_sel) begin
          err_d[ERR_SEQ] = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          err_d[ERR_UNSTABLE] = !fields_stable;
          if (PREADY) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else if (wait_q >= WAIT_LAST) begin
            // Abandon the transfer; nothing is counted for it.
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d            = ST_IDLE;
          end else begin
            wait_d  = wait_q + 1'b1;
            state_d = ST_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Tracker state, wait counter, done flag and SETUP capture registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the values from before this edge, regardless of statement order.
    if (PRESET) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      done_q    <= 1'b0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
      cap_sel   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      done_q  <= complete;
      if (capture) begin
        cap_addr  <= PADDR;
        cap_write <= PWRITE;
        cap_wdata <= PWDATA;
        cap_strb  <= PSTRB;
        cap_sel   <= PSEL;
      end
    end
  end

  // Error pulse, sticky bits and saturating error-cycle counter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      err_cnt    <= '0;
    end else begin
      err_pulse <= err_d;
      if (err_clr) begin
        // A clear never hides an error seen in the same sample.
        err_sticky <= err_d;
        err_cnt    <= (|err_d) ? CNT_WIDTH'(1) : '0;
      end else begin
        err_sticky <= err_sticky | err_d;
        if ((|err_d) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign err_any = |err_sticky;

`ifdef APB_MON_STATS_EN
  // Completed-transfer statistics, all saturating.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      slverr_cnt <= '0;
    end else if (complete) begin
      if (PWRITE) begin
        if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
      end else begin
        if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      end
      if (PSLVERR && (slverr_cnt != '1)) slverr_cnt <= slverr_cnt + 1'b1;
    end
  end
`else
  assign wr_cnt     = '0;
  assign rd_cnt     = '0;
  assign slverr_cnt = '0;

  // PSLVERR only feeds the statistics; keep it visibly consumed.
  logic stats_unused;
  assign stats_unused = PSLVERR;
`endif

endmodule
